// File: rtl/alu_addsub_driver_pkg.sv
// alu_addsub_driver_pkg: ALU function codes, driver FSM states and opcode legality helper
package alu_addsub_driver_pkg;
  localparam logic [3:0] FUNC_ADD = 4'b0000;
  localparam logic [3:0] FUNC_SUB = 4'b0001;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
  function automatic logic is_legal(input logic [3:0] op);
    return op == FUNC_ADD || op == FUNC_SUB;
  endfunction
endpackage

// File: rtl/alu_addsub_driver.sv
// alu_addsub_driver: registers add/sub commands into the ALU and returns its result over valid/ready
module alu_addsub_driver
  import alu_addsub_driver_pkg::*;
#(
  parameter int data_width  = 16,
  parameter int count_width = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [3:0]             req_op,
  input  logic [data_width-1:0]  req_a,
  input  logic [data_width-1:0]  req_b,
  output logic [data_width-1:0]  alu_operand1,
  output logic [data_width-1:0]  alu_operand2,
  output logic [3:0]             alu_opCode,
  input  logic [data_width-1:0]  alu_result,
  input  logic                   alu_isOverflow,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [data_width-1:0]  rsp_result,
  output logic                   rsp_overflow,
  output logic                   rsp_illegal,
  input  logic                   clr_sticky,
  output logic                   sticky_ovf,
  output logic [count_width-1:0] op_count
);
  state_t state, next_state;
  logic accept, legal;
  assign accept = req_valid && req_ready;
  assign legal  = is_legal(alu_opCode);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next_state;
  always_comb
    next_state = state == IDLE ? (accept ? EXEC : IDLE) :
                 state == EXEC ? RESP :
                 state == RESP ? (rsp_ready ? (req_valid ? EXEC : IDLE) : RESP) : IDLE;
  always_comb begin
    req_ready = state == IDLE || (state == RESP && rsp_ready);
    rsp_valid = state == RESP;
  end
  // Capture happens on the single EXEC edge; the ALU has had a full cycle to settle on alu_*.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      alu_opCode   <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_illegal  <= 1'b0;
      sticky_ovf   <= 1'b0;
      op_count     <= '0;
    end else begin
      if (accept) begin
        alu_operand1 <= req_a;
        alu_operand2 <= req_b;
        alu_opCode   <= req_op;
      end
      if (state == EXEC) begin
        rsp_result   <= legal ? alu_result : '0;
        rsp_overflow <= legal && alu_isOverflow;
        rsp_illegal  <= !legal;
      end
      if (rsp_valid && rsp_ready) op_count <= op_count + count_width'(1);
      sticky_ovf <= (state == EXEC && legal && alu_isOverflow) || (sticky_ovf && !clr_sticky);
    end
endmodule

// File: tb/tb_alu_addsub_driver.sv
// tb_alu_addsub_driver: directed and random commands checked against a transaction-level queue model
module tb_alu_addsub_driver;
  localparam logic [3:0] ADD = 4'b0000;
  localparam logic [3:0] SUB = 4'b0001;
  logic clk = 0, reset_n = 0;
  logic req_valid = 0, req_ready, rsp_ready = 0, clr_sticky = 0;
  logic [3:0] req_op = 0, alu_opCode;
  logic [15:0] req_a = 0, req_b = 0, alu_operand1, alu_operand2, alu_result, rsp_result;
  logic alu_isOverflow, rsp_valid, rsp_overflow, rsp_illegal, sticky_ovf;
  logic [1:0] op_count;
  int n_vec = 0, n_err = 0, cyc = 0;
  typedef struct {logic [15:0] res; logic ovf; logic ill; int acc;} txn_t;
  txn_t q[$];
  logic exp_sticky = 0, acc_flag = 0;
  logic [1:0] exp_cnt = 0;
  logic [15:0] exp_a = 0, exp_b = 0;
  logic [3:0] exp_op = 0;

  alu_addsub_driver #(.data_width(16), .count_width(2)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_opCode(alu_opCode), .alu_result(alu_result), .alu_isOverflow(alu_isOverflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .rsp_illegal(rsp_illegal), .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf), .op_count(op_count)
  );

  // Stand-in add/sub unit; for unknown opcodes it emits junk the driver must suppress.
  always_comb begin
    alu_result = alu_opCode == SUB ? alu_operand1 - alu_operand2 : alu_operand1 + alu_operand2;
    alu_isOverflow = alu_opCode == SUB ?
      (alu_operand1[15] != alu_operand2[15]) && (alu_result[15] != alu_operand1[15]) :
      alu_opCode == ADD ?
      (alu_operand1[15] == alu_operand2[15]) && (alu_result[15] != alu_operand1[15]) : 1'b1;
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic txn_t ref_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input int acc);
    txn_t t;
    int r;
    r = op == SUB ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b));
    t.acc = acc;
    t.ill = !(op == ADD || op == SUB);
    t.res = t.ill ? 16'h0 : r[15:0];
    t.ovf = !t.ill && (r > 32767 || r < -32768);
    return t;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      exp_sticky = 0; exp_cnt = 0; exp_a = 0; exp_b = 0; exp_op = 0; acc_flag = 0;
    end else begin
      check("req_ready", req_ready, q.size() == 0 || (rsp_valid && rsp_ready));
      check("rsp_valid", rsp_valid, q.size() > 0 && cyc - q[0].acc >= 1);
      if (rsp_valid && q.size() > 0) begin
        check("rsp_result", rsp_result, q[0].res);
        check("rsp_overflow", rsp_overflow, q[0].ovf);
        check("rsp_illegal", rsp_illegal, q[0].ill);
      end
      check("sticky_ovf", sticky_ovf, exp_sticky);
      check("op_count", op_count, exp_cnt);
      check("alu_operand1", alu_operand1, exp_a);
      check("alu_operand2", alu_operand2, exp_b);
      check("alu_opCode", alu_opCode, exp_op);
      exp_sticky = (q.size() > 0 && cyc == q[0].acc && q[0].ovf) || (exp_sticky && !clr_sticky);
      if (rsp_valid && rsp_ready && q.size() > 0) begin
        void'(q.pop_front());
        exp_cnt = exp_cnt + 2'd1;
      end
      acc_flag = req_valid && req_ready;
      if (acc_flag) begin
        q.push_back(ref_op(req_op, req_a, req_b, cyc + 1));
        exp_a = req_a; exp_b = req_b; exp_op = req_op;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int k;
    req_op = op; req_a = a; req_b = b; req_valid = 1;
    for (k = 0; k < 20; k++) begin
      step(1);
      if (acc_flag) break;
    end
    if (k == 20) check("accept_timeout", 0, 1);
    req_valid = 0;
  endtask

  initial begin
    step(2);
    check("rst_alu_operand1", alu_operand1, 0);
    check("rst_alu_operand2", alu_operand2, 0);
    check("rst_alu_opCode", alu_opCode, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_overflow", rsp_overflow, 0);
    check("rst_rsp_illegal", rsp_illegal, 0);
    check("rst_sticky", sticky_ovf, 0);
    check("rst_op_count", op_count, 0);
    reset_n = 1; rsp_ready = 1;
    step(1);
    send(ADD, 16'h0005, 16'h0003);
    reset_n = 0;
    #1;
    check("mid_rst_alu_operand1", alu_operand1, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_req_ready", req_ready, 1);
    step(1);
    reset_n = 1;
    step(4);
    send(ADD, 16'h0005, 16'h0003); step(3);
    send(ADD, 16'h7FFF, 16'h0001); step(2);
    send(SUB, 16'h8000, 16'h0001); step(2);
    clr_sticky = 1; send(ADD, 16'h0001, 16'h0001); step(2);
    send(ADD, 16'h7FFF, 16'h7FFF); step(2);
    clr_sticky = 0;
    rsp_ready = 0;
    send(SUB, 16'h0003, 16'h0005);
    req_op = ADD; req_a = 16'h0010; req_b = 16'h0020; req_valid = 1;
    step(7);
    rsp_ready = 1;
    step(1);
    req_valid = 0;
    step(3);
    send(4'b0101, 16'h1234, 16'h1111); step(3);
    for (int i = 0; i < 6; i++) send($urandom_range(0, 1) ? SUB : ADD, 16'($urandom), 16'($urandom));
    step(3);
    for (int i = 0; i < 600; i++) begin
      if (!req_valid || acc_flag) begin
        req_valid = $urandom_range(0, 3) != 0;
        req_op = $urandom_range(0, 7) == 0 ? 4'($urandom) : ($urandom_range(0, 1) ? SUB : ADD);
        req_a = $urandom_range(0, 3) == 0 ? 16'h7FFF + 16'($urandom_range(0, 2)) : 16'($urandom);
        req_b = $urandom_range(0, 3) == 0 ? 16'h8000 - 16'($urandom_range(0, 2)) : 16'($urandom);
      end
      rsp_ready = $urandom_range(0, 2) != 0;
      clr_sticky = $urandom_range(0, 7) == 0;
      step(1);
    end
    req_valid = 0; rsp_ready = 1; clr_sticky = 0;
    step(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_addsub_driver.md
Name: alu_addsub_driver

Overview:
Initiator side of the add/sub ALU interface. It accepts operand/opcode commands over a valid/ready request channel and drives the combinational add/sub unit's operand1/operand2/opCode inputs from registers. It captures the unit's result and isOverflow outputs and returns them over a valid/ready response channel. It also maintains a sticky overflow flag and a completed-operation counter, and sits between the lab testbench or control logic and the ALU datapath.

Parameters:
data_width, 16, operand/result width; must match the attached add/sub unit.
count_width, 8, width of the completed-operation counter.

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  command valid
req_ready  output  1  command accepted when req_valid && req_ready at a clk edge
req_op  input  4  opcode (FUNC_ADD / FUNC_SUB)
req_a  input  data_width  operand1
req_b  input  data_width  operand2
alu_operand1  output  data_width  registered operand to the ALU
alu_operand2  output  data_width  registered operand to the ALU
alu_opCode  output  4  registered opcode to the ALU
alu_result  input  data_width  ALU result (combinational from alu_* outputs)
alu_isOverflow  input  1  ALU signed-overflow flag
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready at a clk edge
rsp_result  output  data_width  captured result
rsp_overflow  output  1  captured overflow
rsp_illegal  output  1  opcode was neither ADD nor SUB
clr_sticky  input  1  synchronous clear of sticky_ovf
sticky_ovf  output  1  set by any response with overflow
op_count  output  count_width  number of completed response handshakes

Behaviour:
- Reset (reset_n=0, async): state IDLE. All outputs are 0: alu_operand1, alu_operand2, alu_opCode, rsp_valid, rsp_result, rsp_overflow, rsp_illegal, sticky_ovf, op_count. Any in-flight command is discarded.
- States: IDLE, EXEC, RESP.
- req_ready = (state==IDLE) || (state==RESP && rsp_ready). It is combinational and does not depend on req_valid.
- Accept (req_valid && req_ready): register req_a, req_b, req_op into alu_operand1, alu_operand2, alu_opCode. Next state is EXEC.
- EXEC lasts exactly one cycle, during which the ALU settles. At the closing edge:
  - Legal op: rsp_result <= alu_result, rsp_overflow <= alu_isOverflow, rsp_illegal <= 0.
  - Illegal op: rsp_result <= 0, rsp_overflow <= 0, rsp_illegal <= 1.
  - rsp_valid <= 1 and state goes to RESP.
- Latency: the response is valid 2 cycles after the accept edge. Throughput is one op per 2 cycles with no backpressure.
- RESP: rsp_* are held stable while rsp_valid && !rsp_ready.
  - On handshake: op_count increments, wrapping modulo 2^count_width.
  - If req_valid is also high in that cycle, the new command is accepted and the state goes to EXEC; otherwise the state goes to IDLE.
  - rsp_valid drops after the handshake edge.
- alu_* outputs hold their last value in IDLE and RESP. They change only on accept.
- sticky_ovf is set at the EXEC capture edge when the op is legal and alu_isOverflow=1. clr_sticky clears it. If clear and set occur in the same cycle, set wins (result is 1).
- req_valid in EXEC is ignored (req_ready=0). The requester must hold the command.
- Arithmetic is fully delegated to the ALU; this block performs no arithmetic other than op_count.

Decomposition:
- Shared package/header: FUNC_ADD=4'b0000 and FUNC_SUB=4'b0001 (existing ALU function constants), plus state encodings IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
- Optional sub-module: alu_addsub_driver_tb_top instantiates this block plus the existing add/sub unit for system-level testing. The driver RTL itself has no sub-module.

Test Plan:
- Reset mid-EXEC (reset_n low for 1 cycle after accepting 5+3): all outputs are 0, state is IDLE, and no response ever appears.
- ADD 0x0005 + 0x0003, rsp_ready=1: rsp_valid is high 2 cycles after accept with result 0x0008, overflow 0, illegal 0; op_count goes 0 -> 1.
- ADD 0x7FFF + 0x0001: result 0x8000, overflow 1, sticky_ovf 1. Then SUB 0x8000 - 0x0001: result 0x7FFF, overflow 1. Then clr_sticky together with a non-overflowing capture leaves sticky_ovf = 0.
- Backpressure: hold rsp_ready=0 for 5 cycles after a SUB 0x0003 - 0x0005 response. rsp_result stays 0xFFFE, overflow stays 0, req_ready stays 0, and a pending req_valid is not accepted. Release rsp_ready with req_valid=1: the handshake and the new accept occur on the same edge.
- Illegal opcode 4'b0101 with a=0x1234, b=0x1111: rsp_illegal 1, result 0x0000, overflow 0, sticky_ovf unchanged.
- count_width=2, 5 back-to-back ops with req_valid and rsp_ready always high: responses every 2 cycles; op_count sequence is 1, 2, 3, 0, 1.
